// File: rtl/soc_sysid_ext.sv
// System-identification slave: ID, timestamp, capabilities, scratch, uptime counter with
// coherent 64-bit snapshot reads, and user constant words behind a fixed-latency read pipe.
module soc_sysid_ext #(
    parameter logic [31:0]  ID_VALUE       = 32'h672380D9,
    parameter logic [31:0]  TIMESTAMP      = 32'h0,
    parameter int unsigned  NUM_USER_WORDS = 0,
    parameter logic [255:0] USER_WORDS     = 256'h0,
    parameter int unsigned  READ_LATENCY   = 1,
    parameter int unsigned  UPTIME_WIDTH   = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] writedata_i,
    input  logic [3:0]  byteenable_i,
    output logic [31:0] readdata_o,
    output logic        readdatavalid_o
);

    logic [UPTIME_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]             cnt_ext;
    logic [31:0]             scratch_q, scratch_d;
    logic [31:0]             shadow_q, shadow_d;
    logic                    freeze_q, freeze_d;
    logic                    wr_en, ctrl_wr, clear;
    logic [31:0]             rdata;

    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             data_q [READ_LATENCY];

    assign cnt_ext = 64'(cnt_q);
    // A simultaneous read wins; the write is dropped.
    assign wr_en   = write_i & ~read_i;
    assign ctrl_wr = wr_en && (address_i == 4'd6) && byteenable_i[0];
    assign clear   = ctrl_wr && writedata_i[0];

    always_comb begin
        rdata = 32'h0;
        case (address_i)
            4'd0: rdata = ID_VALUE;
            4'd1: rdata = TIMESTAMP;
            4'd2: rdata = {8'h01, 8'(UPTIME_WIDTH), 8'(READ_LATENCY), 8'(NUM_USER_WORDS)};
            4'd3: rdata = scratch_q;
            4'd4: rdata = cnt_ext[31:0];
            4'd5: rdata = shadow_q;
            4'd6: rdata = {30'h0, freeze_q, 1'b0};
            4'd7: rdata = 32'h0;
            default: begin
                if (32'(address_i[2:0]) < NUM_USER_WORDS) begin
                    rdata = USER_WORDS[{address_i[2:0], 5'd0} +: 32];
                end
            end
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (address_i == 4'd3) && byteenable_i[b]) begin
                scratch_d[8*b +: 8] = writedata_i[8*b +: 8];
            end
        end
        freeze_d = ctrl_wr ? writedata_i[1] : freeze_q;
        // Clear beats the increment; the increment uses the freeze state before this write.
        if (clear) begin
            cnt_d = '0;
        end else if (freeze_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        shadow_d = (read_i && (address_i == 4'd4)) ? cnt_ext[63:32] : shadow_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            scratch_q <= 32'h0;
            shadow_q  <= 32'h0;
            freeze_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            shadow_q  <= shadow_d;
            freeze_q  <= freeze_d;
        end
    end

    // Data stages only load behind a valid, so the last stage holds the previous response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= 32'h0;
            end
        end else begin
            vld_q[0] <= read_i;
            if (read_i) begin
                data_q[0] <= rdata;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign readdata_o      = data_q[READ_LATENCY-1];
    assign readdatavalid_o = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Directed bench for soc_sysid_ext: register table, read pipeline timing, uptime counter
// control and snapshot coherence, and reset during an in-flight read.
module tb_soc_sysid_ext;

    localparam logic [31:0] TS   = 32'h20240517;
    localparam logic [31:0] CAPS = 32'h01400302;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = 4'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    soc_sysid_ext #(
        .ID_VALUE       (32'h672380D9),
        .TIMESTAMP      (TS),
        .NUM_USER_WORDS (2),
        .USER_WORDS     ({160'h0, 32'hBAD00003, 32'hCAFE0002, 32'hCAFE0001}),
        .READ_LATENCY   (3),
        .UPTIME_WIDTH   (64)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .address_i       (address),
        .read_i          (read),
        .write_i         (write),
        .writedata_i     (writedata),
        .byteenable_i    (byteenable),
        .readdata_o      (readdata),
        .readdatavalid_o (readdatavalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          w;
        bit          r;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction; for reads, waits (bounded) for the response and reports its latency.
    task automatic xact(input bit w, input bit r, input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] d, output int lat);
        @(negedge clock);
        write = w; read = r; address = a; writedata = wd; byteenable = be;
        @(negedge clock);
        write = 1'b0; read = 1'b0;
        d = 32'h0;
        lat = 0;
        if (r) begin
            lat = 1;
            while (!readdatavalid && lat < 10) begin
                @(negedge clock);
                lat++;
            end
            d = readdata;
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        int lat;
        xact(1'b0, 1'b1, a, 32'h0, 4'h0, d, lat);
        chk("read_latency", 32'(lat), 32'd3);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] d;
        int lat;
        xact(1'b1, 1'b0, a, wd, be, d, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        ov [9];
        logic [31:0] od [9];
        logic [31:0] d, v1, v2, lo, hi;
        logic [31:0] exp_b2b [3];
        int          lat;
        bit          seen;

        tbl.push_back('{0, 1, 4'd0,  32'h0,        4'h0,    32'h672380D9, "id"});
        tbl.push_back('{0, 1, 4'd1,  32'h0,        4'h0,    TS,           "timestamp"});
        tbl.push_back('{0, 1, 4'd2,  32'h0,        4'h0,    CAPS,         "caps"});
        tbl.push_back('{0, 1, 4'd3,  32'h0,        4'h0,    32'h0,        "scratch_reset"});
        tbl.push_back('{0, 1, 4'd5,  32'h0,        4'h0,    32'h0,        "shadow_reset"});
        tbl.push_back('{0, 1, 4'd6,  32'h0,        4'h0,    32'h0,        "control_reset"});
        tbl.push_back('{1, 0, 4'd3,  32'hDEADBEEF, 4'b0101, 32'h0,        ""});
        tbl.push_back('{0, 1, 4'd3,  32'h0,        4'h0,    32'h00AD00EF, "scratch_be_0101"});
        tbl.push_back('{1, 0, 4'd3,  32'h12345678, 4'b1010, 32'h0,        ""});
        tbl.push_back('{0, 1, 4'd3,  32'h0,        4'h0,    32'h12AD56EF, "scratch_be_1010"});
        tbl.push_back('{1, 1, 4'd3,  32'h0,        4'hF,    32'h12AD56EF, "read_with_write"});
        tbl.push_back('{0, 1, 4'd3,  32'h0,        4'h0,    32'h12AD56EF, "write_dropped"});
        tbl.push_back('{1, 0, 4'd0,  32'hFFFFFFFF, 4'hF,    32'h0,        ""});
        tbl.push_back('{0, 1, 4'd0,  32'h0,        4'h0,    32'h672380D9, "id_read_only"});
        tbl.push_back('{1, 0, 4'd7,  32'hFFFFFFFF, 4'hF,    32'h0,        ""});
        tbl.push_back('{0, 1, 4'd7,  32'h0,        4'h0,    32'h0,        "reserved"});
        tbl.push_back('{0, 1, 4'd8,  32'h0,        4'h0,    32'hCAFE0001, "user0"});
        tbl.push_back('{0, 1, 4'd9,  32'h0,        4'h0,    32'hCAFE0002, "user1"});
        tbl.push_back('{0, 1, 4'd10, 32'h0,        4'h0,    32'h0,        "user_out_of_range"});
        tbl.push_back('{0, 1, 4'd15, 32'h0,        4'h0,    32'h0,        "user_top"});
        tbl.push_back('{1, 0, 4'd6,  32'h2,        4'h0,    32'h0,        ""});
        tbl.push_back('{0, 1, 4'd6,  32'h0,        4'h0,    32'h0,        "control_no_lane0"});
        tbl.push_back('{1, 0, 4'd6,  32'hFFFFFFFF, 4'h1,    32'h0,        ""});
        tbl.push_back('{0, 1, 4'd6,  32'h0,        4'h0,    32'h2,        "control_mask"});
        tbl.push_back('{1, 0, 4'd6,  32'h0,        4'h1,    32'h0,        ""});
        tbl.push_back('{0, 1, 4'd6,  32'h0,        4'h0,    32'h0,        "control_cleared"});

        repeat (3) @(negedge clock);
        chk("reset_valid", 32'(readdatavalid), 32'd0);
        chk("reset_data", readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Back-to-back reads of words 0..2: responses on three consecutive cycles.
        exp_b2b[0] = 32'h672380D9;
        exp_b2b[1] = TS;
        exp_b2b[2] = CAPS;
        for (int j = 0; j < 9; j++) begin
            @(negedge clock);
            ov[j] = readdatavalid;
            od[j] = readdata;
            read = (j < 3);
            address = 4'(j);
        end
        read = 1'b0;
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("b2b_valid_%0d", j), 32'(ov[j]), 32'(j >= 3 && j <= 5));
            if (j >= 3 && j <= 5) chk($sformatf("b2b_data_%0d", j), od[j], exp_b2b[j-3]);
        end
        chk("b2b_data_hold", od[8], CAPS);

        foreach (tbl[i]) begin
            xact(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].be, d, lat);
            if (tbl[i].r) begin
                chk(tbl[i].name, d, tbl[i].exp);
                chk({tbl[i].name, "_latency"}, 32'(lat), 32'd3);
            end
        end

        // Read in the cycle right after a write sees the new value.
        @(negedge clock);
        write = 1'b1; address = 4'd3; writedata = 32'h55AA55AA; byteenable = 4'hF;
        @(negedge clock);
        write = 1'b0; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        lat = 1;
        while (!readdatavalid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        chk("write_then_read", readdata, 32'h55AA55AA);

        rd(4'd4, v1);
        rd(4'd4, v2);
        chk("uptime_running", v2 - v1, 32'd4);

        wr(4'd6, 32'h1, 4'h1);
        rd(4'd4, v1);
        chk("uptime_after_clear", v1, 32'd1);

        wr(4'd6, 32'h2, 4'h1);
        rd(4'd4, v1);
        repeat (10) @(negedge clock);
        rd(4'd4, v2);
        chk("uptime_frozen", v2, v1);

        wr(4'd6, 32'h3, 4'h1);
        rd(4'd4, v1);
        chk("clear_freeze_a", v1, 32'h0);
        repeat (5) @(negedge clock);
        rd(4'd4, v1);
        chk("clear_freeze_b", v1, 32'h0);

        wr(4'd6, 32'h0, 4'h1);
        rd(4'd4, v1);
        rd(4'd4, v2);
        chk("unfreeze_first", v1, 32'd1);
        chk("unfreeze_step", v2 - v1, 32'd4);

        // Jump the counter just below the 32-bit carry and check LO/HI snapshot pairs.
        @(negedge clock);
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFC;
        #1 release dut.cnt_q;
        rd(4'd4, lo);
        rd(4'd5, hi);
        chk("snap_lo_pre", lo, 32'hFFFFFFFD);
        chk("snap_hi_pre", hi, 32'h0);
        rd(4'd4, lo);
        rd(4'd5, hi);
        chk("snap_lo_post", lo, 32'h00000005);
        chk("snap_hi_post", hi, 32'h1);

        // Reset one cycle after a read is accepted: its response must never appear.
        @(negedge clock);
        read = 1'b1; address = 4'd0;
        @(negedge clock);
        read = 1'b0;
        reset_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen |= readdatavalid;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            seen |= readdatavalid;
        end
        chk("reset_drops_read", 32'(seen), 32'd0);
        chk("reset_readdata", readdata, 32'h0);
        rd(4'd3, d);
        chk("scratch_after_reset", d, 32'h0);
        rd(4'd5, d);
        chk("shadow_after_reset", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
